mem_arbiter: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/arb_streak_counter.sv | 40 ++++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, data word and the memory arbiter grant state.
// Also provides the sizing helper for the arbiter's streak counter.
package cpu_types_pkg;

  localparam int unsigned WordW = 32;

  typedef logic [WordW-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  // Counter must represent 0..max_val, and is never narrower than 3 bits.
  function automatic int unsigned streak_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants completed while a fetch was waiting.
// force_i_o asks the arbiter to grant instruction next once the limit is reached.
module arb_streak_counter #(
  parameter int unsigned StreakMax = 4,
  parameter int unsigned StreakW   = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               i_req_i,
  input  logic               i_done_i,
  input  logic               d_done_i,
  output logic [StreakW-1:0] streak_o,
  output logic               force_i_o
);

  localparam logic [StreakW-1:0] MaxVal = StreakW'(StreakMax);

  logic [StreakW-1:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    if (i_done_i || (d_done_i && !i_req_i)) begin
      streak_d = '0;
    end else if (d_done_i && i_req_i && (streak_q != MaxVal)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign streak_o  = streak_q;
  assign force_i_o = (streak_q == MaxVal) && i_req_i;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, data-priority with a
// bounded data streak. Define MEM_ARBITER_STATS_EN to add grant/starvation counters.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
`ifdef MEM_ARBITER_STATS_EN
  output logic [31:0] igrants_cnt,
  output logic [31:0] dgrants_cnt,
  output logic [31:0] starve_cnt,
`endif
  input  logic [1:0]  ramstate
);

  localparam int unsigned StreakW = streak_width(STREAK_MAX);

  arb_state_t         state_q, state_d;
  ramstate_t          ram_st;
  logic               dreq, igrant, dgrant, access;
  logic               i_done, d_done, force_i;
  logic [StreakW-1:0] streak;

  assign ram_st = ramstate_t'(ramstate);
  assign dreq   = dREN | dWEN;
  assign access = (ram_st == ACCESS);
  // Reset masks the grant so the strobes drop in the reset cycle itself.
  assign igrant = (state_q == IGRANT) && !RST;
  assign dgrant = (state_q == DGRANT) && !RST;
  assign i_done = igrant && iREN && access;
  assign d_done = dgrant && dreq && access;

  arb_streak_counter #(
    .StreakMax (STREAK_MAX),
    .StreakW   (StreakW)
  ) u_streak (
    .clk_i     (CLK),
    .rst_i     (RST),
    .i_req_i   (iREN),
    .i_done_i  (i_done),
    .d_done_i  (d_done),
    .streak_o  (streak),
    .force_i_o (force_i)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dreq && !force_i) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      // A dropped request aborts the grant without a completion.
      IGRANT: if (!iREN || access) state_d = IDLE;
      DGRANT: if (!dreq || access) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RAM side follows the granted requester's live inputs; ERROR keeps them up for retry.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (igrant) begin
      ramREN  = iREN;
      ramaddr = iaddr;
    end else if (dgrant) begin
      ramREN   = dREN;
      ramWEN   = dWEN;
      ramaddr  = daddr;
      ramstore = dstore;
    end
  end

  always_comb begin
    iwait = iREN;
    dwait = dreq;
    iload = '0;
    dload = '0;
    if (igrant) begin
      iwait = !i_done;
      if (i_done) iload = ramload;
    end
    if (dgrant) begin
      dwait = !d_done;
      if (d_done) dload = ramload;
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] igrants_q, igrants_d;
  logic [31:0] dgrants_q, dgrants_d;
  logic [31:0] starve_q, starve_d;

  always_comb begin
    igrants_d = igrants_q + {31'd0, i_done};
    dgrants_d = dgrants_q + {31'd0, d_done};
    starve_d  = starve_q + {31'd0, (iREN && (state_q != IGRANT))};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      igrants_q <= '0;
      dgrants_q <= '0;
      starve_q  <= '0;
    end else begin
      igrants_q <= igrants_d;
      dgrants_q <= dgrants_d;
      starve_q  <= starve_d;
    end
  end

  assign igrants_cnt = igrants_q;
  assign dgrants_cnt = dgrants_q;
  assign starve_cnt  = starve_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a latency-programmable RAM model, expected completions
// queued in arbitration order and popped by a completion monitor.
module tb_mem_arbiter;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] igrants_cnt, dgrants_cnt, starve_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int i_done_n = 0;
  int d_done_n = 0;
  int unsigned busy_n = 0;
  int unsigned err_n = 0;
  int unsigned ram_cnt = 0;

  typedef struct packed {
    logic        is_d;
    logic        is_wr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];

  mem_arbiter #(.STREAK_MAX(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .dREN        (dREN),
    .dWEN        (dWEN),
    .daddr       (daddr),
    .dstore      (dstore),
    .iwait       (iwait),
    .dwait       (dwait),
    .iload       (iload),
    .dload       (dload),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramload     (ramload),
`ifdef MEM_ARBITER_STATS_EN
    .igrants_cnt (igrants_cnt),
    .dgrants_cnt (dgrants_cnt),
    .starve_cnt  (starve_cnt),
`endif
    .ramstate    (ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C010004;
    return {a[15:0], ~a[15:0]};
  endfunction

  // RAM model: err_n ERROR cycles, then busy_n BUSY cycles, then ACCESS.
  always_comb begin
    ramstate = 2'd0;
    if (ramREN || ramWEN) begin
      if (ram_cnt < err_n) ramstate = 2'd3;
      else if (ram_cnt < err_n + busy_n) ramstate = 2'd1;
      else ramstate = 2'd2;
    end
  end

  assign ramload = (ramstate == 2'd2) ? mem_word(ramaddr) : 32'h0;

  always @(posedge CLK) begin
    ram_cnt <= ((ramREN || ramWEN) && (ramstate != 2'd2)) ? ram_cnt + 1 : 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input logic is_d, input logic [31:0] val);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_unexpected_completion", {31'd0, is_d}, 32'hFFFF_FFFF);
    end else begin
      e = sb_q.pop_front();
      check("sb_kind", {31'd0, is_d}, {31'd0, e.is_d});
      check(e.is_wr ? "sb_store" : (is_d ? "sb_dload" : "sb_iload"), val, e.data);
    end
  endtask

  // Completion monitor
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (iREN && !iwait) begin
          i_done_n++;
          sb_pop(1'b0, iload);
        end
        if ((dREN || dWEN) && !dwait) begin
          d_done_n++;
          sb_pop(1'b1, dWEN ? ramstore : dload);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  task automatic push(input logic is_d, input logic is_wr, input logic [31:0] data);
    exp_t e;
    e.is_d  = is_d;
    e.is_wr = is_wr;
    e.data  = data;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    RST  = 1'b1;
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic wait_done(input logic is_d, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 80 && !ok; n++) begin
      neg();
      ok = is_d ? (dREN && !dwait) : (iREN && !iwait);
    end
  endtask

  task automatic drive_d();
    logic ok;
    for (int k = 0; k < 6; k++) begin
      daddr = 32'h200 + 32'(4 * k);
      dREN  = 1'b1;
      wait_done(1'b1, ok);
      if (!ok) begin
        check("starve_d_timeout", 32'd0, 32'd1);
        break;
      end
      step();
    end
    dREN = 1'b0;
  endtask

  task automatic drive_i();
    logic ok;
    iaddr = 32'h300;
    iREN  = 1'b1;
    wait_done(1'b0, ok);
    if (!ok) check("starve_i_timeout", 32'd0, 32'd1);
    step();
    iREN = 1'b0;
  endtask

  initial begin
    int base_i, base_d;
`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] ig_base;
`endif
    RST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    step(); step();
    neg();
    check("rst_ramREN", {31'd0, ramREN}, 32'd0);
    check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_iload", iload, 32'd0);
    check("rst_dload", dload, 32'd0);
    check("rst_iwait_follows", {31'd0, iwait}, 32'd1);
    check("rst_dwait_follows", {31'd0, dwait}, 32'd0);
    check("rst_streak", 32'(dut.streak), 32'd0);
    step();
    iREN = 1'b0;
    RST  = 1'b0;
    step();

    // Single fetch, two BUSY cycles
    busy_n = 2; base_i = i_done_n;
    iREN = 1'b1; iaddr = 32'h40;
    push(1'b0, 1'b0, 32'h8C010004);
    neg(); check("sf_c0_ramREN", {31'd0, ramREN}, 32'd0); step();
    neg(); check("sf_c1_ramREN", {31'd0, ramREN}, 32'd1);
    check("sf_c1_ramaddr", ramaddr, 32'h40);
    check("sf_c1_iwait", {31'd0, iwait}, 32'd1); step();
    neg(); check("sf_c2_iwait", {31'd0, iwait}, 32'd1); step();
    neg(); check("sf_c3_iwait", {31'd0, iwait}, 32'd0);
    check("sf_c3_iload", iload, 32'h8C010004); step();
    neg(); check("sf_c4_idle_ramREN", {31'd0, ramREN}, 32'd0);
    check("sf_c4_iwait", {31'd0, iwait}, 32'd1);
    check("sf_pulse_count", 32'(i_done_n - base_i), 32'd1);
    step(); iREN = 1'b0; step(); step();

    // Collision: write wins, fetch after one turnaround cycle
    do_reset();
    busy_n = 0;
    iREN = 1'b1; iaddr = 32'h80;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    push(1'b1, 1'b1, 32'hDEADBEEF);
    push(1'b0, 1'b0, mem_word(32'h80));
    neg(); check("col_c0_ramWEN", {31'd0, ramWEN}, 32'd0); step();
    neg(); check("col_c1_ramWEN", {31'd0, ramWEN}, 32'd1);
    check("col_c1_ramREN", {31'd0, ramREN}, 32'd0);
    check("col_c1_ramaddr", ramaddr, 32'h100);
    check("col_c1_dwait", {31'd0, dwait}, 32'd0); step();
    dWEN = 1'b0;
    neg(); check("col_c2_ramREN", {31'd0, ramREN}, 32'd0);
    check("col_c2_ramWEN", {31'd0, ramWEN}, 32'd0); step();
    neg(); check("col_c3_ramREN", {31'd0, ramREN}, 32'd1);
    check("col_c3_ramaddr", ramaddr, 32'h80);
    check("col_c3_iwait", {31'd0, iwait}, 32'd0); step();
    iREN = 1'b0; step();

    // Starvation: four data grants, forced fetch, then remaining loads
    do_reset();
    busy_n = 1; base_i = i_done_n; base_d = d_done_n;
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, mem_word(32'h200 + 32'(4 * k)));
    push(1'b0, 1'b0, mem_word(32'h300));
    for (int k = 4; k < 6; k++) push(1'b1, 1'b0, mem_word(32'h200 + 32'(4 * k)));
    fork
      drive_d();
      drive_i();
    join
    step();
    check("starve_i_count", 32'(i_done_n - base_i), 32'd1);
    check("starve_d_count", 32'(d_done_n - base_d), 32'd6);
    check("starve_sb_drained", 32'(sb_q.size()), 32'd0);

    // Abort a BUSY data grant, then a normal fetch
    do_reset();
    busy_n = 10; base_d = d_done_n;
    dREN = 1'b1; daddr = 32'h400;
    step();
    neg(); check("ab_c1_ramREN", {31'd0, ramREN}, 32'd1);
    check("ab_c1_dwait", {31'd0, dwait}, 32'd1); step();
    dREN = 1'b0;
    neg(); check("ab_c2_ramREN", {31'd0, ramREN}, 32'd0); step();
    neg(); check("ab_c3_ramREN", {31'd0, ramREN}, 32'd0); step();
    busy_n = 0; iREN = 1'b1; iaddr = 32'h44;
    push(1'b0, 1'b0, mem_word(32'h44));
    neg(); check("ab_c4_ramREN", {31'd0, ramREN}, 32'd0); step();
    neg(); check("ab_c5_ramaddr", ramaddr, 32'h44);
    check("ab_c5_iwait", {31'd0, iwait}, 32'd0); step();
    iREN = 1'b0;
    check("ab_no_d_completion", 32'(d_done_n - base_d), 32'd0);
    step();

    // Reset during a BUSY fetch with a non-zero streak
    do_reset();
    busy_n = 0;
    iREN = 1'b1; iaddr = 32'h48;
    dREN = 1'b1; daddr = 32'h500;
    push(1'b1, 1'b0, mem_word(32'h500));
    push(1'b0, 1'b0, mem_word(32'h48));
    step();
    neg(); check("rm_c1_dwait", {31'd0, dwait}, 32'd0); step();
    dREN = 1'b0; busy_n = 10;
    step();
    neg(); check("rm_c3_ramREN", {31'd0, ramREN}, 32'd1);
    check("rm_c3_ramaddr", ramaddr, 32'h48);
    check("rm_c3_streak", 32'(dut.streak), 32'd1); step();
    RST = 1'b1;
    neg(); check("rm_c4_ramREN", {31'd0, ramREN}, 32'd0);
    check("rm_c4_ramaddr", ramaddr, 32'd0);
    check("rm_c4_iwait", {31'd0, iwait}, 32'd1); step();
    RST = 1'b0; busy_n = 0;
    neg(); check("rm_c5_idle_ramREN", {31'd0, ramREN}, 32'd0);
    check("rm_c5_streak", 32'(dut.streak), 32'd0); step();
    neg(); check("rm_c6_iwait", {31'd0, iwait}, 32'd0); step();
    iREN = 1'b0; step();

    // ERROR retry: three ERROR cycles then ACCESS
    do_reset();
    err_n = 3; busy_n = 0; base_i = i_done_n;
`ifdef MEM_ARBITER_STATS_EN
    ig_base = igrants_cnt;
`endif
    iREN = 1'b1; iaddr = 32'h4C;
    push(1'b0, 1'b0, mem_word(32'h4C));
    step();
    for (int c = 1; c <= 3; c++) begin
      neg();
      check("err_ramREN_held", {31'd0, ramREN}, 32'd1);
      check("err_ramaddr_held", ramaddr, 32'h4C);
      check("err_iwait_high", {31'd0, iwait}, 32'd1);
      step();
    end
    neg(); check("err_access_iwait", {31'd0, iwait}, 32'd0); step();
    iREN = 1'b0; err_n = 0;
    step();
    check("err_pulse_count", 32'(i_done_n - base_i), 32'd1);
`ifdef MEM_ARBITER_STATS_EN
    check("err_igrants_delta", igrants_cnt - ig_base, 32'd1);
`endif

    check("sb_left_over", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
